time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Timekeeping core of the digital clock; sits directly downstream of the校时 (adjust) control.
- Counts seconds, minutes and hours in packed BCD from a 1 Hz enable tick.
- In adjust mode, consumes the single-cycle hour_en / min_en pulses to step hours or minutes by one.
- Feeds the display/scan stage and the hourly chime logic.

Parameters:
- HOURS, 24, hour modulus; legal values 24 or 12. For 12, hours run 01..12 and wrap 12->01.
- SEC_CLR_ON_ADJ, 1, when 1 seconds are forced to 00 while adj_mode=1; when 0 seconds freeze.

Ports:
- clk  input  1  system clock (CP2, 100 Hz domain); all state changes on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- tick_1hz  input  1  single-cycle enable, one per second, synchronous to clk.
- adj_mode  input  1  K0 level: 1 = adjust mode (counting halted), 0 = run mode.
- hour_en  input  1  single-cycle pulse: hours +1 (honoured only when adj_mode=1).
- min_en  input  1  single-cycle pulse: minutes +1 (honoured only when adj_mode=1).
- sec_bcd  output  8  seconds, packed BCD {tens, ones}, range 00..59.
- min_bcd  output  8  minutes, packed BCD, range 00..59.
- hour_bcd  output  8  hours, packed BCD, range 00..23 (HOURS=24) or 01..12 (HOURS=12).
- hour_pulse  output  1  one-cycle pulse on run-mode rollover mm:ss 59:59 -> 00:00.
- sec_pulse  output  1  one-cycle pulse whenever sec_bcd advances in run mode.

Behaviour:
- Reset (async, rst_n=0):
  - sec_bcd=00, min_bcd=00, hour_pulse=0, sec_pulse=0.
  - hour_bcd=00 when HOURS=24; hour_bcd=12 when HOURS=12.
- All outputs are registers. The effect of an input sampled on edge N is visible after edge N; there is no combinational input-to-output path.
- Digit arithmetic:
  - Each BCD nibble counts 0..9. Ones 9 -> 0 with a carry into tens.
  - Seconds and minutes wrap 59 -> 00.
  - Hours wrap 23 -> 00 (HOURS=24) or 12 -> 01 (HOURS=12).
  - Nibble values A..F are never produced.
- Run mode (adj_mode=0), on a tick_1hz edge:
  - Seconds +1; sec_pulse=1 for that cycle.
  - If seconds wrap, minutes +1.
  - If minutes also wrap, hours +1 and hour_pulse=1 for that cycle.
  - The full carry chain resolves in one cycle, e.g. 23:59:59 -> 00:00:00 in one edge.
- Run mode, no tick: all state holds; hour_en and min_en are ignored.
- Adjust mode (adj_mode=1):
  - tick_1hz is ignored; sec_pulse=0 and hour_pulse=0 throughout.
  - hour_en: hours +1 with wrap. Minutes and seconds are unaffected.
  - min_en: minutes +1 with wrap, and no carry into hours (59 -> 00, hours unchanged).
  - hour_en and min_en in the same cycle: both applied independently.
  - Seconds: forced to 00 every cycle if SEC_CLR_ON_ADJ=1, otherwise held.
- Mode transitions:
  - adj_mode 1 -> 0: counting resumes on the next tick_1hz. No catch-up for ticks that arrived during adjust.
  - adj_mode 0 -> 1 in the same cycle as a tick: adjust wins, and the tick is dropped.
- Reset mid-operation forces reset values immediately. The first tick after release advances from the reset values.
- Consecutive ticks on back-to-back cycles are each honoured; no minimum tick spacing is required.

Test Plan:
- Reset, then 60 ticks -> sec_bcd steps 00..59 then 00, min_bcd=01, sec_pulse high exactly 60 cycles, hour_pulse never high.
- Preload via adjust to 23:59, SEC_CLR_ON_ADJ=0 with seconds at 59, leave adjust, one tick -> 00:00:00 in one edge, hour_pulse=1 for exactly one cycle.
- adj_mode=1, 25 hour_en pulses from 00 -> hour_bcd=01 (wrap at 23->00), min_bcd unchanged. HOURS=12 build: 12 -> 01 on the pulse after 12.
- adj_mode=1, min_bcd=59, one min_en -> min_bcd=00 and hour_bcd unchanged. hour_en+min_en in the same cycle from 05:30 -> 06:31.
- adj_mode=1 with tick_1hz toggling, hour_en/min_en pulsed in run mode -> no change to any count (seconds 00 if SEC_CLR_ON_ADJ=1), no pulses emitted.
- Assert rst_n low at 12:34:56 between ticks -> outputs 00:00:00 asynchronously, before the next clk edge. Release, one tick -> 00:00:01.

Source files
------------

// File: rtl/time_counter_if.sv
// Bundles the control inputs and BCD time outputs of time_counter.
// The master modport belongs to the adjust/tick source; the slave modport belongs to the counter.
interface time_counter_if;
  logic       tick_1hz;
  logic       adj_mode;
  logic       hour_en;
  logic       min_en;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       hour_pulse;
  logic       sec_pulse;

  modport master (
    output tick_1hz, adj_mode, hour_en, min_en,
    input  sec_bcd, min_bcd, hour_bcd, hour_pulse, sec_pulse
  );

  modport slave (
    input  tick_1hz, adj_mode, hour_en, min_en,
    output sec_bcd, min_bcd, hour_bcd, hour_pulse, sec_pulse
  );
endinterface

// File: rtl/time_counter.sv
// Packed-BCD hh:mm:ss timekeeper advanced by a 1 Hz enable tick.
// In adjust mode it steps hours or minutes from single-cycle pulses instead.
module time_counter #(
  parameter int HOURS          = 24,
  parameter bit SEC_CLR_ON_ADJ = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  time_counter_if.slave bus
);

  localparam logic [7:0] HOUR_RESET = (HOURS == 12) ? 8'h12 : 8'h00;
  localparam logic [7:0] HOUR_LAST  = (HOURS == 12) ? 8'h12 : 8'h23;
  localparam logic [7:0] HOUR_WRAP  = (HOURS == 12) ? 8'h01 : 8'h00;

  logic [7:0] sec_q, min_q, hour_q;
  logic [7:0] sec_next, min_next, hour_next;
  logic       sec_pulse_q, hour_pulse_q;
  logic       sec_pulse_next, hour_pulse_next;
  logic       sec_wrap, min_wrap;

  // Wraps to first at last, so nibbles A..F are never produced.
  function automatic logic [7:0] bcd_step(input logic [7:0] value,
                                          input logic [7:0] last,
                                          input logic [7:0] first);
    logic [7:0] result;
    if (value == last) begin
      result = first;
    end else if (value[3:0] >= 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

  assign sec_wrap = (sec_q == 8'h59);
  assign min_wrap = (min_q == 8'h59);

  always_comb begin
    sec_next        = sec_q;
    min_next        = min_q;
    hour_next       = hour_q;
    sec_pulse_next  = 1'b0;
    hour_pulse_next = 1'b0;
    if (bus.adj_mode) begin
      // Adjust mode ignores the tick; minute steps never carry into hours.
      if (SEC_CLR_ON_ADJ) begin
        sec_next = 8'h00;
      end
      if (bus.hour_en) begin
        hour_next = bcd_step(hour_q, HOUR_LAST, HOUR_WRAP);
      end
      if (bus.min_en) begin
        min_next = bcd_step(min_q, 8'h59, 8'h00);
      end
    end else if (bus.tick_1hz) begin
      sec_next       = bcd_step(sec_q, 8'h59, 8'h00);
      sec_pulse_next = 1'b1;
      if (sec_wrap) begin
        min_next = bcd_step(min_q, 8'h59, 8'h00);
        if (min_wrap) begin
          hour_next       = bcd_step(hour_q, HOUR_LAST, HOUR_WRAP);
          hour_pulse_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      hour_q       <= HOUR_RESET;
      sec_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
    end else begin
      sec_q        <= sec_next;
      min_q        <= min_next;
      hour_q       <= hour_next;
      sec_pulse_q  <= sec_pulse_next;
      hour_pulse_q <= hour_pulse_next;
    end
  end

  assign bus.sec_bcd    = sec_q;
  assign bus.min_bcd    = min_q;
  assign bus.hour_bcd   = hour_q;
  assign bus.sec_pulse  = sec_pulse_q;
  assign bus.hour_pulse = hour_pulse_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench: a 24-hour/clear-on-adjust and a 12-hour/freeze-on-adjust counter
// share one stimulus stream and are compared against an integer time model.
module tb_time_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic adj = 1'b0;
  logic hen = 1'b0;
  logic men = 1'b0;

  int compared = 0;
  int mismatched = 0;

  int m_s[2];
  int m_m[2];
  int m_h[2];
  bit m_sp[2];
  bit m_hp[2];

  time_counter_if bus24 ();
  time_counter_if bus12 ();

  assign bus24.tick_1hz = tick;
  assign bus24.adj_mode = adj;
  assign bus24.hour_en  = hen;
  assign bus24.min_en   = men;
  assign bus12.tick_1hz = tick;
  assign bus12.adj_mode = adj;
  assign bus12.hour_en  = hen;
  assign bus12.min_en   = men;

  time_counter #(.HOURS(24), .SEC_CLR_ON_ADJ(1'b1)) dut24 (
    .clk(clk), .rst_n(rst_n), .bus(bus24));
  time_counter #(.HOURS(12), .SEC_CLR_ON_ADJ(1'b0)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12));

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Instance 0 is the 24-hour clock, instance 1 the 12-hour clock (01..12).
  function automatic int next_hour(input int i, input int h);
    return (i == 0) ? (h + 1) % 24 : (h % 12) + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s[i] = 0;
      m_m[i] = 0;
      m_h[i] = (i == 0) ? 0 : 12;
      m_sp[i] = 1'b0;
      m_hp[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_sp[i] = 1'b0;
      m_hp[i] = 1'b0;
      if (adj) begin
        if (i == 0) m_s[i] = 0;
        if (hen) m_h[i] = next_hour(i, m_h[i]);
        if (men) m_m[i] = (m_m[i] + 1) % 60;
      end else if (tick) begin
        m_sp[i] = 1'b1;
        if (m_s[i] == 59) begin
          m_s[i] = 0;
          if (m_m[i] == 59) begin
            m_m[i] = 0;
            m_h[i] = next_hour(i, m_h[i]);
            m_hp[i] = 1'b1;
          end else begin
            m_m[i] = m_m[i] + 1;
          end
        end else begin
          m_s[i] = m_s[i] + 1;
        end
      end
    end
  endtask

  task automatic compare(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_output(input string tag);
    compare({tag, " sec24"},   bus24.sec_bcd,  to_bcd(m_s[0]));
    compare({tag, " min24"},   bus24.min_bcd,  to_bcd(m_m[0]));
    compare({tag, " hour24"},  bus24.hour_bcd, to_bcd(m_h[0]));
    compare({tag, " spulse24"}, {7'd0, bus24.sec_pulse},  {7'd0, m_sp[0]});
    compare({tag, " hpulse24"}, {7'd0, bus24.hour_pulse}, {7'd0, m_hp[0]});
    compare({tag, " sec12"},   bus12.sec_bcd,  to_bcd(m_s[1]));
    compare({tag, " min12"},   bus12.min_bcd,  to_bcd(m_m[1]));
    compare({tag, " hour12"},  bus12.hour_bcd, to_bcd(m_h[1]));
    compare({tag, " spulse12"}, {7'd0, bus12.sec_pulse},  {7'd0, m_sp[1]});
    compare({tag, " hpulse12"}, {7'd0, bus12.hour_pulse}, {7'd0, m_hp[1]});
  endtask

  task automatic apply_stimulus(input bit t, input bit a, input bit h, input bit m, input string tag);
    tick = t;
    adj  = a;
    hen  = h;
    men  = m;
    @(posedge clk);
    model_step();
    #1;
    check_output(tag);
  endtask

  task automatic adjust_to(input int hour24, input int minute);
    for (int k = 0; k < 30 && m_h[0] != hour24; k++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, "adj hour");
    for (int k = 0; k < 60 && m_m[0] != minute; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, "adj min");
  endtask

  int sp_count;
  int hp_count;

  initial begin
    $display("[TB] start");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset");
    compare("reset hour12 const", bus12.hour_bcd, 8'h12);
    #3 rst_n = 1'b1;

    // Sixty ticks: one full minute of seconds.
    sp_count = 0;
    hp_count = 0;
    for (int k = 0; k < 60; k++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "run60");
      sp_count += int'(bus24.sec_pulse);
      hp_count += int'(bus24.hour_pulse);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "run60 idle");
    compare("run60 sec const", bus24.sec_bcd, 8'h00);
    compare("run60 min const", bus24.min_bcd, 8'h01);
    compare("run60 sec_pulse count", 8'(sp_count), 8'd60);
    compare("run60 hour_pulse count", 8'(hp_count), 8'd0);

    // Preload 23:59, then tick seconds up to 59 and roll the whole day over.
    adjust_to(23, 59);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "leave adj");
    for (int k = 0; k < 59; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "to 59s");
    compare("pre-roll time", bus24.hour_bcd, 8'h23);
    compare("pre-roll sec", bus24.sec_bcd, 8'h59);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "rollover");
    compare("roll hour", bus24.hour_bcd, 8'h00);
    compare("roll min", bus24.min_bcd, 8'h00);
    compare("roll sec", bus24.sec_bcd, 8'h00);
    compare("roll hour_pulse", {7'd0, bus24.hour_pulse}, 8'd1);
    compare("roll hour12", bus12.hour_bcd, 8'h12);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "post roll");
    compare("post roll hour_pulse", {7'd0, bus24.hour_pulse}, 8'd0);

    // 25 hour steps from 00 land on 01; the 12-hour clock goes 12 -> 01 first.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, "hour25");
    compare("hour12 wrap", bus12.hour_bcd, 8'h01);
    for (int k = 1; k < 25; k++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, "hour25");
    compare("hour25 hour", bus24.hour_bcd, 8'h01);
    compare("hour25 min", bus24.min_bcd, 8'h00);

    adjust_to(1, 59);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, "min wrap");
    compare("min wrap min", bus24.min_bcd, 8'h00);
    compare("min wrap hour", bus24.hour_bcd, 8'h01);

    adjust_to(5, 30);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, "both en");
    compare("both hour", bus24.hour_bcd, 8'h06);
    compare("both min", bus24.min_bcd, 8'h31);

    // Ticks ignored in adjust; pulses ignored in run.
    for (int k = 0; k < 8; k++) apply_stimulus(1'(k % 2), 1'b1, 1'b0, 1'b0, "adj tick");
    for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 1'b0, 1'(k % 2), 1'b1, "run en");
    compare("hold hour", bus24.hour_bcd, 8'h06);
    compare("hold min", bus24.min_bcd, 8'h31);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, "enter adj with tick");
    compare("dropped tick sec_pulse", {7'd0, bus24.sec_pulse}, 8'd0);

    // Async reset at 12:34:56 between edges.
    adjust_to(12, 34);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "leave adj2");
    for (int k = 0; k < 56; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "to 56s");
    compare("pre-reset sec", bus24.sec_bcd, 8'h56);
    tick = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async reset");
    compare("async reset hour", bus24.hour_bcd, 8'h00);
    #1 rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "first tick");
    compare("first tick sec", bus24.sec_bcd, 8'h01);

    for (int k = 0; k < 400; k++) begin
      bit a;
      a = ($urandom_range(0, 15) == 0) ? ~adj : adj;
      apply_stimulus(1'($urandom_range(0, 1)), a,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
